ah_wrr_arbiter: RTL

Parametrised weighted round-robin arbiter with registered one-hot grant and a valid/ready grant handshake. It generalises the fixed 16-requester arbiter to N requesters with WW-bit per-requester credits and a runtime mode select (plain round-robin or weighted). It sits in front of shared resources such as bus ports and memory banks. The downstream consumer accepts each grant explicitly, and the arbiter holds the grant stable until accepted.

---
 rtl/ah_wrr_arbiter_if.sv | 27 ++
 rtl/ah_wrr_arbiter.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ah_wrr_arbiter_if.sv
// Request/grant bundle between requesters, the consumer and ah_wrr_arbiter.
// master = requester/consumer side, slave = arbiter side.
interface ah_wrr_arbiter_if #(
  parameter int N  = 16,
  parameter int WW = 6
);
  localparam int IW = $clog2(N);

  logic [N-1:0]    req;
  logic            cfg_mode;
  logic [N*WW-1:0] cfg_weight;
  logic            gnt_ready;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IW-1:0]   grant_id;
  logic            refresh;

  modport master (
    output req, cfg_mode, cfg_weight, gnt_ready,
    input  grant, grant_valid, grant_id, refresh
  );

  modport slave (
    input  req, cfg_mode, cfg_weight, gnt_ready,
    output grant, grant_valid, grant_id, refresh
  );
endinterface

// File: rtl/ah_wrr_arbiter.sv
// Weighted round-robin arbiter: N requesters, per-requester WW-bit credits,
// registered one-hot grant held until the consumer accepts it.
module ah_wrr_arbiter #(
  parameter int N  = 16,
  parameter int WW = 6
) (
  input logic          clk,
  input logic          rst_n,
  ah_wrr_arbiter_if.slave bus
);
  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_EXT  = (IW+1)'(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [N-1:0]  grant_q, grant_d;
  logic          grant_valid_q, grant_valid_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic          refresh_q, refresh_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] credit_q [N];
  logic [WW-1:0] credit_d [N];

  logic          slot_free;
  logic [N-1:0]  credit_nz;
  logic [N-1:0]  weight_nz;
  logic [N-1:0]  eligible;
  logic [N-1:0]  refill_cand;
  logic          do_refill;
  logic [N-1:0]  cand;
  logic          found;
  logic [IW-1:0] win;
  logic [IW:0]   idx;
  logic [WW-1:0] base_credit;
  logic [WW-1:0] post_credit;
  logic [IW-1:0] win_next;

  // A held grant blocks arbitration; gnt_ready without a grant is harmless.
  assign slot_free = !grant_valid_q || bus.gnt_ready;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      credit_nz[i] = (credit_q[i] != '0);
      weight_nz[i] = (bus.cfg_weight[i*WW +: WW] != '0);
    end
  end

  assign eligible    = bus.req & credit_nz;
  assign refill_cand = bus.req & weight_nz;
  assign do_refill   = bus.cfg_mode && (eligible == '0) && (refill_cand != '0);

  always_comb begin
    if (!bus.cfg_mode) begin
      cand = bus.req;
    end else if (do_refill) begin
      cand = refill_cand;
    end else begin
      cand = eligible;
    end
  end

  // Circular search starting at ptr; idx is one bit wider so the wrap is a
  // plain subtract and works for non-power-of-two N.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(k);
      if (idx >= N_EXT) begin
        idx = idx - N_EXT;
      end
      if (!found && cand[idx[IW-1:0]]) begin
        found = 1'b1;
        win   = idx[IW-1:0];
      end
    end
  end

  assign base_credit = do_refill ? bus.cfg_weight[win*WW +: WW] : credit_q[win];
  assign post_credit = base_credit - WW'(1);
  assign win_next    = (win == LAST) ? '0 : win + IW'(1);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    refresh_d     = 1'b0;
    ptr_d         = ptr_q;
    credit_d      = credit_q;

    if (slot_free) begin
      grant_valid_d = found;
      grant_d       = '0;
      if (found) begin
        grant_d[win] = 1'b1;
        grant_id_d   = win;
        refresh_d    = do_refill;
        if (bus.cfg_mode) begin
          if (do_refill) begin
            for (int i = 0; i < N; i++) begin
              credit_d[i] = bus.cfg_weight[i*WW +: WW];
            end
          end
          credit_d[win] = post_credit;
          ptr_d         = (post_credit != '0) ? win : win_next;
        end else begin
          ptr_d = win_next;
        end
      end
    end
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      refresh_q     <= 1'b0;
      ptr_q         <= '0;
      // NOTE: the credit array is reset, unlike a data RAM: zero credits are
      // what force the first weighted arbitration to refresh.
      for (int i = 0; i < N; i++) begin
        credit_q[i] <= '0;
      end
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      refresh_q     <= refresh_d;
      ptr_q         <= ptr_d;
      for (int i = 0; i < N; i++) begin
        credit_q[i] <= credit_d[i];
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.refresh     = refresh_q;
endmodule
